// File: rtl/nco_pkg.sv
// nco_pkg: quadrant encoding, mirror/negate helpers and quarter-wave table generator for the NCO.
package nco_pkg;
  localparam int PHASE_W_DEF = 32;
  localparam int LUT_AW_DEF = 10;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  function automatic logic mirrored(input logic [1:0] q);
    return q == Q1 || q == Q3;
  endfunction
  function automatic logic negated(input logic [1:0] q);
    return !(q == Q0 || q == Q1);
  endfunction
  // Half-LSB phase offset makes the table mirror-symmetric across quadrants.
  function automatic int quarter_sine(input int idx, input int aw, input int mw);
    real x;
    x = (real'(idx) + 0.5) * 3.141592653589793 / real'(2 ** (aw + 1));
    return $rtoi(real'(2 ** mw - 1) * $sin(x) + 0.5);
  endfunction
endpackage

// File: rtl/nco_if.sv
// nco_if: control and valid/ready sample stream of the NCO; cosine present only with COS_OUT_EN.
interface nco_if #(parameter int DATA_W = 16, parameter int PHASE_W = 32);
  logic en;
  logic ftw_wr;
  logic phase_clr;
  logic [PHASE_W-1:0] ftw_in;
  logic [PHASE_W-1:0] pow_in;
  logic out_valid;
  logic out_ready;
  logic signed [DATA_W-1:0] sine;
`ifdef COS_OUT_EN
  logic signed [DATA_W-1:0] cosine;
  modport master(input en, ftw_wr, phase_clr, ftw_in, pow_in, out_ready, output out_valid, sine, cosine);
  modport slave(output en, ftw_wr, phase_clr, ftw_in, pow_in, out_ready, input out_valid, sine, cosine);
`else
  modport master(input en, ftw_wr, phase_clr, ftw_in, pow_in, out_ready, output out_valid, sine);
  modport slave(output en, ftw_wr, phase_clr, ftw_in, pow_in, out_ready, input out_valid, sine);
`endif
endinterface

// File: rtl/quarter_sine_rom.sv
// quarter_sine_rom: synchronous-read quarter-wave magnitude table, contents generated at elaboration.
module quarter_sine_rom
  import nco_pkg::*;
#(
  parameter int AW = 10,
  parameter int MAG_W = 15
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  output logic [MAG_W-1:0] o_data
);
  logic [MAG_W-1:0] w_rom [2**AW];
  logic [MAG_W-1:0] r_data;
  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    assign w_rom[i] = MAG_W'(quarter_sine(i, AW, MAG_W));
  end
  always_ff @(posedge clk)
    if (i_en) r_data <= w_rom[i_addr];
  assign o_data = r_data;
endmodule

// File: rtl/nco_sine_generator.sv
// nco_sine_generator: phase-accumulator NCO with quarter-wave ROM and valid/ready output.
// Define COS_OUT_EN to build the second (cosine) read path.
module nco_sine_generator
  import nco_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(32'h0100_0000)
) (
  input logic clk,
  input logic rst,
  nco_if.master bus
);
  logic w_adv, w_load;
  logic [PHASE_W-1:0] r_acc, r_ftw, r_ph;
  logic r_v0, r_v1, r_vo;
  logic [1:0] w_quad, r_q1;
  logic [LUT_AW-1:0] w_a;
  logic [PHASE_W-LUT_AW-3:0] w_unused_lsb;
  logic [DATA_W-2:0] w_mag;
  logic [DATA_W-1:0] w_mag_x;
  logic signed [DATA_W-1:0] r_sine;
  assign w_adv = !r_vo || bus.out_ready;
  assign w_load = w_adv && bus.en;
  assign {w_quad, w_a, w_unused_lsb} = r_ph + bus.pow_in;
  assign w_mag_x = {1'b0, w_mag};
  quarter_sine_rom #(.AW(LUT_AW), .MAG_W(DATA_W-1)) u_rom (
    .clk(clk), .i_en(w_adv), .i_addr(mirrored(w_quad) ? ~w_a : w_a), .o_data(w_mag)
  );
  // r_ph is stage S0: the phase of the sample that entered, r_acc the next phase to issue.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc <= '0;
      r_ftw <= FTW_RST;
      r_ph <= '0;
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_vo <= 1'b0;
      r_q1 <= '0;
      r_sine <= '0;
    end else begin
      if (bus.ftw_wr) r_ftw <= bus.ftw_in;
      if (w_load) begin
        r_ph <= r_acc;
        r_acc <= bus.phase_clr ? '0 : r_acc + r_ftw;
      end
      if (w_adv) begin
        r_v0 <= bus.en;
        r_v1 <= r_v0;
        r_vo <= r_v1;
        r_q1 <= w_quad;
        r_sine <= negated(r_q1) ? -w_mag_x : w_mag_x;
      end
    end
  assign bus.out_valid = r_vo;
  assign bus.sine = r_sine;
`ifdef COS_OUT_EN
  logic [1:0] w_quad_c, r_qc;
  logic [DATA_W-2:0] w_mag_c;
  logic [DATA_W-1:0] w_mag_cx;
  logic signed [DATA_W-1:0] r_cos;
  assign w_quad_c = w_quad + 2'd1;
  assign w_mag_cx = {1'b0, w_mag_c};
  quarter_sine_rom #(.AW(LUT_AW), .MAG_W(DATA_W-1)) u_rom_c (
    .clk(clk), .i_en(w_adv), .i_addr(mirrored(w_quad_c) ? ~w_a : w_a), .o_data(w_mag_c)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_qc <= '0;
      r_cos <= '0;
    end else if (w_adv) begin
      r_qc <= w_quad_c;
      r_cos <= negated(r_qc) ? -w_mag_cx : w_mag_cx;
    end
  assign bus.cosine = r_cos;
`endif
endmodule

// File: tb/tb_nco_sine_generator.sv
// tb_nco_sine_generator: sample-stream model check plus directed literal expectations for the NCO.
module tb_nco_sine_generator;
  localparam int DW = 16;
  localparam int PW = 32;
  localparam int AW = 10;
  localparam int SH = PW - AW - 2;
  localparam logic [31:0] FTW_DEF = 32'h0100_0000;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  nco_if #(.DATA_W(DW), .PHASE_W(PW)) bus();
  nco_sine_generator #(.DATA_W(DW), .PHASE_W(PW), .LUT_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int q_s[$];
  int q_c[$];
  int got[$];
  logic [31:0] m_acc, m_ftw;
  logic prev_stall;
  int prev_s, prev_c;
  int pat_s[4] = '{25, 32767, -25, -32767};
  int pat_c[4] = '{32767, -25, -32767, 25};
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Ideal sample: full-circle index of the phase, sine of its bin centre, rounded away from zero.
  function automatic int ref_val(input logic [31:0] p, input bit cosw);
    int n;
    real y;
    n = (int'(p >> SH) + (cosw ? 1024 : 0)) % 4096;
    y = 32767.0 * $sin((real'(n) + 0.5) * 2.0 * 3.141592653589793 / 4096.0);
    return y < 0.0 ? -$rtoi(-y + 0.5) : $rtoi(y + 0.5);
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q_s.delete();
      q_c.delete();
      m_acc = '0;
      m_ftw = FTW_DEF;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_sine", bus.sine, prev_s);
`ifdef COS_OUT_EN
        chk("hold_cosine", bus.cosine, prev_c);
`endif
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q_s.size() == 0) chk("extra_sample", 1, 0);
        else begin
          chk("stream_sine", bus.sine, q_s.pop_front());
          got.push_back(int'(bus.sine));
`ifdef COS_OUT_EN
          chk("stream_cosine", bus.cosine, q_c.pop_front());
          chk("amplitude", $sqrt(real'(bus.sine) ** 2 + real'(bus.cosine) ** 2) > 32764.9 &&
                           $sqrt(real'(bus.sine) ** 2 + real'(bus.cosine) ** 2) < 32769.1, 1);
`endif
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_s = int'(bus.sine);
`ifdef COS_OUT_EN
      prev_c = int'(bus.cosine);
`endif
      if ((!bus.out_valid || bus.out_ready) && bus.en) begin
        q_s.push_back(ref_val(m_acc + bus.pow_in, 1'b0));
        q_c.push_back(ref_val(m_acc + bus.pow_in, 1'b1));
        m_acc = bus.phase_clr ? 32'd0 : m_acc + m_ftw;
      end
      if (bus.ftw_wr) m_ftw = bus.ftw_in;
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic restart(input logic [31:0] ftw, input logic [31:0] pow);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.out_ready = 1'b1;
    bus.phase_clr = 1'b0;
    cyc(1);
    rst = 1'b0;
    bus.pow_in = pow;
    bus.ftw_in = ftw;
    bus.ftw_wr = 1'b1;
    cyc(1);
    bus.ftw_wr = 1'b0;
    bus.en = 1'b1;
    cyc(3);
    got.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int sum, mx;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.ftw_wr = 1'b0;
    bus.ftw_in = '0;
    bus.pow_in = '0;
    bus.phase_clr = 1'b0;
    bus.out_ready = 1'b1;
    cyc(2);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sine", bus.sine, 0);
    rst = 1'b0;
    bus.en = 1'b1;
    cyc(2);
    chk("latency_not_yet", bus.out_valid, 0);
    cyc(1);
    chk("first_valid", bus.out_valid, 1);
    chk("first_sine", bus.sine, 25);
    cyc(20);
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_sine", bus.sine, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("rerst_valid", bus.out_valid, 1);
    chk("rerst_sine", bus.sine, 25);
    restart(32'h4000_0000, 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("quad_sine", bus.sine, pat_s[k % 4]);
`ifdef COS_OUT_EN
      chk("quad_cosine", bus.cosine, pat_c[k % 4]);
`endif
      cyc(1);
    end
    restart(32'h4000_0000, 32'h4000_0000);
    for (int k = 0; k < 4; k++) begin
      chk("pow_sine", bus.sine, pat_s[(k + 1) % 4]);
`ifdef COS_OUT_EN
      chk("pow_cosine", bus.cosine, pat_c[(k + 1) % 4]);
`endif
      cyc(1);
    end
    restart(FTW_DEF, 32'h0);
    cyc(4096);
    chk("no_bubbles", got.size(), 4096);
    chk("t3_first", got.size() > 0 ? got[0] : 0, 25);
    for (int p = 0; p < 16 && got.size() >= 4096; p++) begin
      sum = 0;
      mx = -65536;
      for (int j = 0; j < 256; j++) begin
        sum += got[p * 256 + j];
        if (got[p * 256 + j] > mx) mx = got[p * 256 + j];
      end
      chk("period_sum", sum, 0);
      chk("period_max", mx, 32767);
    end
    restart(FTW_DEF, 32'h0);
    cyc(20);
    bus.out_ready = 1'b0;
    cyc(10);
    chk("stall_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    cyc(20);
    chk("bp_count", got.size(), 40);
    restart(FTW_DEF, 32'h0);
    for (int i = 0; i < 300 && got.size() < 100; i++) cyc(1);
    chk("ftw_reach", got.size() >= 100, 1);
    bus.ftw_in = 32'h0200_0000;
    bus.ftw_wr = 1'b1;
    cyc(1);
    bus.ftw_wr = 1'b0;
    cyc(40);
    bus.phase_clr = 1'b1;
    cyc(1);
    bus.phase_clr = 1'b0;
    cyc(6);
    bus.out_ready = 1'b0;
    cyc(3);
    bus.out_ready = 1'b1;
    bus.en = 1'b0;
    cyc(6);
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_queue", q_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
